hps_io_csr_slave: RTL and testbench

- FPGA-side Avalon-MM responder behind the HPS lightweight H2F bridge.
- Gives HPS software register access to board switches, keys and LEDs, replacing the stock PIO pair.
- Adds input synchronisation, debounce, per-bit edge capture and a level interrupt to the HPS.
- Sits in the Qsys system; exports connect directly to SW, KEY and LED at the top level.

---
 rtl/hps_io_csr_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_hps_io_csr_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_io_csr_slave.sv
// hps_io_csr_slave: Avalon-MM register slave behind the HPS lightweight bridge.
// Conditions board switches and keys with a synchroniser and a tick-based
// debounce, captures per-bit edges, raises a level interrupt and drives LEDs.
module hps_io_csr_slave #(
  parameter int unsigned NUM_SW          = 4,
  parameter int unsigned NUM_KEY         = 2,
  parameter int unsigned NUM_LED         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] ID_VALUE        = 32'h1D10_0001
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic [3:0]         avs_byteenable,
  output logic [31:0]        avs_readdata,
  output logic               avs_readdatavalid,
  output logic               irq,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic [NUM_KEY-1:0] key_in,
  output logic [NUM_LED-1:0] led_out
);

  localparam int unsigned NS = NUM_SW + NUM_KEY;
  localparam int unsigned PW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_MASK    = 3'd3;
  localparam logic [2:0] ADDR_LED     = 3'd4;
  localparam logic [2:0] ADDR_SCRATCH = 3'd5;

  // Expand the four byte enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Synchroniser stages; keys are inverted so that 1 means pressed.
  logic [NUM_SW-1:0]  sw_meta_q, sw_sync_q;
  logic [NUM_KEY-1:0] key_meta_q, key_sync_q;
  logic [NS-1:0]      sync_vec_s;

  // Sample tick generation.
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_s;

  // Debounce, arming and edge capture.
  logic [NS-1:0] prev_q, stat_q, stat_d, stable_s, edge_set_s;
  logic          tick_seen_q, armed_q;

  // Software-visible registers.
  logic [NS-1:0]      edge_q, edge_d, edge_clr_s;
  logic [NS-1:0]      mask_q, mask_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [31:0]        scratch_q, scratch_d;
  logic [31:0]        wr_lanes_s;
  logic               irq_q;

  // Read path.
  logic [31:0] stat_ext_s, edge_ext_s, mask_ext_s, led_ext_s;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;

  assign sync_vec_s        = {key_sync_q, sw_sync_q};
  assign tick_s            = (presc_q == PRESC_LAST);
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = irq_q;
  assign led_out           = led_q;

  // Two-flop synchronisers for the raw switch and key pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '0;
      key_sync_q <= '0;
    end else begin
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= ~key_in;
      key_sync_q <= key_meta_q;
    end
  end

  // Prescaler wraps at DEBOUNCE_CYCLES-1; the wrap cycle is the tick.
  always_comb begin
    presc_d = presc_q;
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Debounced status: free load before arming, otherwise a bit follows the
  // sample only when it matched the previous tick's sample.
  always_comb begin
    stat_d     = stat_q;
    edge_set_s = '0;
    stable_s   = ~(sync_vec_s ^ prev_q);
    if (tick_s) begin
      if (!armed_q) begin
        stat_d = sync_vec_s;
      end else begin
        stat_d = (stat_q & ~stable_s) | (sync_vec_s & stable_s);
      end
    end else begin
      stat_d = stat_q;
    end
    if (tick_s && armed_q) begin
      edge_set_s = stat_d ^ stat_q;
    end else begin
      edge_set_s = '0;
    end
  end

  // Register writes with byte lanes; an edge set beats a same-cycle clear.
  always_comb begin
    wr_lanes_s = lane_mask(avs_byteenable);
    edge_clr_s = '0;
    mask_d     = mask_q;
    led_d      = led_q;
    scratch_d  = scratch_q;
    if (avs_write) begin
      case (avs_address)
        ADDR_EDGE:    edge_clr_s = avs_writedata[NS-1:0] & wr_lanes_s[NS-1:0];
        ADDR_MASK:    mask_d = (mask_q & ~wr_lanes_s[NS-1:0]) |
                               (avs_writedata[NS-1:0] & wr_lanes_s[NS-1:0]);
        ADDR_LED:     led_d = (led_q & ~wr_lanes_s[NUM_LED-1:0]) |
                              (avs_writedata[NUM_LED-1:0] & wr_lanes_s[NUM_LED-1:0]);
        ADDR_SCRATCH: scratch_d = (scratch_q & ~wr_lanes_s) | (avs_writedata & wr_lanes_s);
        default:      edge_clr_s = '0;
      endcase
    end else begin
      edge_clr_s = '0;
    end
    edge_d = (edge_q & ~edge_clr_s) | edge_set_s;
  end

  // Zero-extend the narrow registers and select read data (pre-write values).
  always_comb begin
    stat_ext_s = 32'h0;
    edge_ext_s = 32'h0;
    mask_ext_s = 32'h0;
    led_ext_s  = 32'h0;
    stat_ext_s[NS-1:0]      = stat_q;
    edge_ext_s[NS-1:0]      = edge_q;
    mask_ext_s[NS-1:0]      = mask_q;
    led_ext_s[NUM_LED-1:0]  = led_q;
    rdata_d = 32'h0;
    if (avs_read) begin
      case (avs_address)
        ADDR_ID:      rdata_d = ID_VALUE;
        ADDR_STATUS:  rdata_d = stat_ext_s;
        ADDR_EDGE:    rdata_d = edge_ext_s;
        ADDR_MASK:    rdata_d = mask_ext_s;
        ADDR_LED:     rdata_d = led_ext_s;
        ADDR_SCRATCH: rdata_d = scratch_q;
        default:      rdata_d = 32'h0;
      endcase
    end else begin
      rdata_d = 32'h0;
    end
  end

  // Tick counter, debounce state and arming after the second tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      prev_q      <= '0;
      stat_q      <= '0;
      tick_seen_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      presc_q <= presc_d;
      stat_q  <= stat_d;
      if (tick_s) begin
        prev_q <= sync_vec_s;
        if (!armed_q) begin
          if (tick_seen_q) begin
            armed_q <= 1'b1;
          end else begin
            tick_seen_q <= 1'b1;
          end
        end
      end
    end
  end

  // Software registers and the interrupt line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q    <= '0;
      mask_q    <= '0;
      led_q     <= '0;
      scratch_q <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      mask_q    <= mask_d;
      led_q     <= led_d;
      scratch_q <= scratch_d;
      irq_q     <= |(edge_q & mask_q);
    end
  end

  // Fixed latency-1 read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= avs_read;
    end
  end

endmodule

// File: tb/tb_hps_io_csr_slave.sv
// Self-checking bench for hps_io_csr_slave with a fast debounce tick.
module tb_hps_io_csr_slave;

  localparam int NSW = 4;
  localparam int NKEY = 2;
  localparam int NLED = 8;
  localparam int DC = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [NSW-1:0]  sw_in;
  logic [NKEY-1:0] key_in;
  logic [NLED-1:0] led_out;

  int checks;
  int errors;

  hps_io_csr_slave #(
    .NUM_SW(NSW), .NUM_KEY(NKEY), .NUM_LED(NLED),
    .DEBOUNCE_CYCLES(DC), .ID_VALUE(32'h1D10_0001)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .irq(irq), .sw_in(sw_in), .key_in(key_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  // Reference model: pin history, tick count, and the register file as plain values.
  logic [5:0]  m_pin_d1, m_pin_d2;  // {pressed keys, switches} one and two clocks ago
  logic [5:0]  m_prev, m_status, m_edge, m_mask;
  logic [7:0]  m_led;
  logic [31:0] m_scratch, m_rdata;
  logic        m_rvalid, m_irq;
  int          m_cnt, m_ticks;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pin_d1 = '0; m_pin_d2 = '0; m_prev = '0; m_status = '0;
    m_edge = '0; m_mask = '0; m_led = '0; m_scratch = '0;
    m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0; m_cnt = 0; m_ticks = 0;
  endtask

  function automatic logic [31:0] m_regval(input logic [2:0] a);
    case (a)
      3'd0: return 32'h1D10_0001;
      3'd1: return {26'h0, m_status};
      3'd2: return {26'h0, m_edge};
      3'd3: return {26'h0, m_mask};
      3'd4: return {24'h0, m_led};
      3'd5: return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] bytes_of(input logic [3:0] be);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) r = r | (32'hFF << (8 * b));
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [5:0]  seen, s_new, set_v, clr_v;
    logic [31:0] lm, t;
    logic        tick, armed;
    seen  = m_pin_d2;
    tick  = ((m_cnt % DC) == DC - 1);
    armed = (m_ticks >= 2);
    lm    = bytes_of(avs_byteenable);
    m_rvalid = avs_read;
    m_rdata  = avs_read ? m_regval(avs_address) : 32'h0;
    m_irq    = |(m_edge & m_mask);
    s_new = m_status;
    if (tick) begin
      for (int i = 0; i < 6; i++) begin
        if (!armed || seen[i] == m_prev[i]) s_new[i] = seen[i];
      end
    end
    set_v = (tick && armed) ? (s_new ^ m_status) : 6'h0;
    clr_v = 6'h0;
    if (avs_write) begin
      t = avs_writedata & lm;
      if (avs_address == 3'd2) clr_v = t[5:0];
      if (avs_address == 3'd3) begin
        t = ({26'h0, m_mask} & ~lm) | (avs_writedata & lm);
        m_mask = t[5:0];
      end
      if (avs_address == 3'd4) begin
        t = ({24'h0, m_led} & ~lm) | (avs_writedata & lm);
        m_led = t[7:0];
      end
      if (avs_address == 3'd5) m_scratch = (m_scratch & ~lm) | (avs_writedata & lm);
    end
    m_edge = (m_edge & ~clr_v) | set_v;
    if (tick) begin
      m_prev = seen;
      if (m_ticks < 2) m_ticks++;
    end
    m_status = s_new;
    m_pin_d2 = m_pin_d1;
    m_pin_d1 = {~key_in, sw_in};
    m_cnt++;
  endtask

  task automatic set_bus(input logic rd, input logic wr, input logic [2:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    avs_read = rd; avs_write = wr; avs_address = a;
    avs_writedata = d; avs_byteenable = be;
  endtask

  task automatic set_idle();
    set_bus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
  endtask

  task automatic do_cycle(input bit cmp);
    model_step();
    @(posedge clk);
    #1;
    if (cmp) begin
      check("rvalid", {31'h0, avs_readdatavalid}, {31'h0, m_rvalid});
      check("rdata", avs_readdata, m_rdata);
      check("irq", {31'h0, irq}, {31'h0, m_irq});
      check("led", {24'h0, led_out}, {24'h0, m_led});
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
    set_bus(1'b1, 1'b0, a, 32'h0, 4'h0);
    do_cycle(1'b1);
    v = avs_readdata;
    set_idle();
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    set_bus(1'b0, 1'b1, a, d, be);
    do_cycle(1'b1);
    set_idle();
  endtask

  initial begin
    logic [31:0] v;
    int  polls;
    bit  found;
    bit  hit;

    tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,         4'h0, 1'b1, 32'h1D10_0001, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 3'd4, 32'h0,         4'h0, 1'b1, 32'h0,         8'h00};
    tbl[2]  = '{1'b0, 1'b1, 3'd4, 32'h0000_00A5, 4'h1, 1'b0, 32'h0,         8'hA5};
    tbl[3]  = '{1'b0, 1'b1, 3'd4, 32'hFFFF_FF00, 4'hE, 1'b0, 32'h0,         8'hA5};
    tbl[4]  = '{1'b1, 1'b0, 3'd4, 32'h0,         4'h0, 1'b1, 32'h0000_00A5, 8'hA5};
    tbl[5]  = '{1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         8'hA5};
    tbl[6]  = '{1'b1, 1'b1, 3'd5, 32'h1234_5678, 4'hF, 1'b1, 32'hDEAD_BEEF, 8'hA5};
    tbl[7]  = '{1'b1, 1'b0, 3'd5, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 8'hA5};
    tbl[8]  = '{1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         8'hA5};
    tbl[9]  = '{1'b1, 1'b0, 3'd6, 32'h0,         4'h0, 1'b1, 32'h0,         8'hA5};
    tbl[10] = '{1'b1, 1'b0, 3'd1, 32'h0,         4'h0, 1'b1, 32'h0000_0003, 8'hA5};
    tbl[11] = '{1'b1, 1'b0, 3'd2, 32'h0,         4'h0, 1'b1, 32'h0,         8'hA5};
    tbl[12] = '{1'b0, 1'b1, 3'd3, 32'hFFFF_FFFF, 4'h1, 1'b0, 32'h0,         8'hA5};
    tbl[13] = '{1'b1, 1'b0, 3'd3, 32'h0,         4'h0, 1'b1, 32'h0000_003F, 8'hA5};
    tbl[14] = '{1'b0, 1'b1, 3'd4, 32'h0,         4'h0, 1'b0, 32'h0,         8'hA5};
    tbl[15] = '{1'b1, 1'b0, 3'd7, 32'h0,         4'h0, 1'b1, 32'h0,         8'hA5};

    checks = 0; errors = 0;
    clk = 1'b0; reset_n = 1'b0;
    sw_in = 4'b0011; key_in = 2'b11;
    set_idle();
    model_reset();

    // Reset state.
    @(posedge clk); #1;
    check("reset_rdata", avs_readdata, 32'h0);
    check("reset_rvalid", {31'h0, avs_readdatavalid}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_led", {24'h0, led_out}, 32'h0);
    reset_n = 1'b1;

    // Table-driven bus accesses; switches held at 0011 since reset.
    for (int i = 0; i < 16; i++) begin
      set_bus(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      do_cycle(1'b0);
      check($sformatf("tbl%0d_rvalid", i), {31'h0, avs_readdatavalid}, {31'h0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_rdata", i), avs_readdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_led", i), {24'h0, led_out}, {24'h0, tbl[i].exp_led});
    end
    set_idle();

    // Three-cycle glitch on sw_in[2] must not reach STATUS or EDGE.
    sw_in = 4'b0111;
    for (int i = 0; i < 3; i++) do_cycle(1'b1);
    sw_in = 4'b0011;
    for (int i = 0; i < 12; i++) do_cycle(1'b1);
    read_reg(3'd1, v); check("glitch_status", v, 32'h0000_0003);
    read_reg(3'd2, v); check("glitch_edge", v, 32'h0);

    // Key press with MASK=0x10: STATUS bit 4 within 2+8 cycles, then EDGE and irq.
    write_reg(3'd3, 32'h0000_0010, 4'h1);
    key_in = 2'b10;
    found = 1'b0; polls = 0;
    for (int i = 0; i < 14; i++) begin
      if (!found) begin
        read_reg(3'd1, v);
        polls++;
        if (v[4]) found = 1'b1;
      end
    end
    check("key_status_seen", {31'h0, found}, 32'h1);
    check("key_latency", (polls <= 11) ? 32'h1 : 32'h0, 32'h1);
    do_cycle(1'b1);
    read_reg(3'd2, v); check("key_edge", v, 32'h0000_0010);
    check("key_irq", {31'h0, irq}, 32'h1);

    // Clear EDGE bit 4 in the very cycle a sw_in[0] change is debounced.
    sw_in = 4'b0010;
    hit = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!hit) begin
        if (((m_cnt % DC) == DC - 1) && (m_ticks >= 2) &&
            (m_pin_d2[0] == m_prev[0]) && (m_pin_d2[0] != m_status[0])) begin
          hit = 1'b1;
          set_bus(1'b0, 1'b1, 3'd2, 32'h0000_0010, 4'hF);
        end else begin
          set_idle();
        end
        do_cycle(1'b1);
      end
    end
    set_idle();
    check("collision_found", {31'h0, hit}, 32'h1);
    read_reg(3'd2, v); check("collision_edge", v, 32'h0000_0001);
    check("collision_irq", {31'h0, irq}, 32'h0);
    write_reg(3'd5, 32'hDEAD_BEEF, 4'hF);
    read_reg(3'd5, v); check("scratch", v, 32'hDEAD_BEEF);

    // Reset with a read response pending: it must vanish immediately.
    set_bus(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
    do_cycle(1'b1);
    set_idle();
    #2 reset_n = 1'b0;
    #1;
    check("midreset_rvalid", {31'h0, avs_readdatavalid}, 32'h0);
    check("midreset_led", {24'h0, led_out}, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) do_cycle(1'b1);
    read_reg(3'd2, v); check("rearm_edge", v, 32'h0);
    read_reg(3'd1, v); check("rearm_status", v, {26'h0, ~key_in, sw_in});

    // Randomised traffic and slowly changing pins against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 39) == 0) sw_in = 4'($urandom);
      if ($urandom_range(0, 59) == 0) key_in = 2'($urandom);
      r = $urandom_range(0, 9);
      if (r < 4)
        set_bus(1'b1, 1'b0, 3'($urandom), 32'h0, 4'h0);
      else if (r < 6)
        set_bus(1'b0, 1'b1, 3'($urandom), $urandom, 4'($urandom));
      else if (r == 6)
        set_bus(1'b1, 1'b1, 3'($urandom), $urandom, 4'($urandom));
      else
        set_idle();
      do_cycle(1'b1);
    end
    set_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
